ddr_burst_arbiter: RTL

//  Shares the single DDR burst-controller request port (rd/wr req+len+addr, wr data, rd data) among NUM_CH requesters.

---
 rtl/ddr_burst_arbiter_pkg.sv | 25 ++
 rtl/ddr_burst_arbiter_rr_pick.sv | 30 +++
 rtl/ddr_burst_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_burst_arbiter_pkg.sv
// Shared types and constants for the DDR burst arbiter.
package ddr_burst_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Burst direction encoding of ch_dir_i
    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    localparam int unsigned TIMEOUT_CYC_DEF = 4096;
    localparam int unsigned LEN_W           = 8;
    localparam int unsigned TCNT_W          = 16;

    // Increment with wrap back to zero at n
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 1) >= n) ? 0 : (v + 1);
    endfunction

endpackage

// File: rtl/ddr_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module ddr_burst_arbiter_rr_pick
    import ddr_burst_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   idx,
    output logic              valid
);

    logic [CH_W-1:0] k;

    // Scan from ptr upward; the first hit wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            k = CH_W'((32'(ptr) + i) % NUM_CH);
            if (!valid && req[k]) begin
                valid = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter sharing one DDR burst-controller port among NUM_CH requesters.
module ddr_burst_arbiter
    import ddr_burst_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CH_W          = $clog2(NUM_CH),
    parameter int unsigned ADDR_WIDTH    = 30,
    parameter int unsigned MEM_DATA_BITS = 256,
    parameter int unsigned TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
    input  logic                            ddr_clk_i,
    input  logic                            ddr_rst_i,
    input  logic                            local_init_done_i,
    input  logic [NUM_CH-1:0]               ch_req_i,
    input  logic [NUM_CH-1:0]               ch_dir_i,
    input  logic [NUM_CH*LEN_W-1:0]         ch_len_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]    ch_addr_i,
    input  logic [NUM_CH*MEM_DATA_BITS-1:0] ch_wr_data_i,
    output logic [NUM_CH-1:0]               ch_grant_o,
    output logic [NUM_CH-1:0]               ch_done_o,
    output logic [NUM_CH-1:0]               ch_wr_data_req_o,
    output logic [NUM_CH-1:0]               ch_rd_valid_o,
    output logic [MEM_DATA_BITS-1:0]        rd_data_o,
    output logic                            timeout_err_o,
    output logic [TCNT_W-1:0]               timeout_cnt_o,
    output logic                            rd_ddr_req_o,
    output logic [LEN_W-1:0]                rd_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]           rd_ddr_addr_o,
    output logic                            wr_ddr_req_o,
    output logic [LEN_W-1:0]                wr_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]           wr_ddr_addr_o,
    output logic [MEM_DATA_BITS-1:0]        wr_ddr_data_o,
    input  logic                            wr_ddr_data_req_i,
    input  logic                            rd_ddr_data_valid_i,
    input  logic [MEM_DATA_BITS-1:0]        rd_ddr_data_i,
    input  logic                            rd_ddr_finish_i,
    input  logic                            wr_ddr_finish_i,
    input  logic                            burst_idle_i
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC) + 1;

    // Per-channel views of the packed request buses
    logic [LEN_W-1:0]         len_arr  [NUM_CH];
    logic [ADDR_WIDTH-1:0]    addr_arr [NUM_CH];
    logic [MEM_DATA_BITS-1:0] data_arr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign len_arr[g]  = ch_len_i[LEN_W*g +: LEN_W];
        assign addr_arr[g] = ch_addr_i[ADDR_WIDTH*g +: ADDR_WIDTH];
        assign data_arr[g] = ch_wr_data_i[MEM_DATA_BITS*g +: MEM_DATA_BITS];
    end

    arb_state_t              state_q, state_d;
    logic [CH_W-1:0]         idx_q, idx_d;
    logic                    dir_q, dir_d;
    logic                    zero_q, zero_d;
    logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
    logic [NUM_CH-1:0]       grant_q, grant_d;
    logic [NUM_CH-1:0]       done_q, done_d;
    logic                    terr_q, terr_d;
    logic                    rd_req_q, rd_req_d;
    logic                    wr_req_q, wr_req_d;
    logic [LEN_W-1:0]        rd_len_q, rd_len_d;
    logic [LEN_W-1:0]        wr_len_q, wr_len_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;

    logic [CH_W-1:0]         pick_idx;
    logic                    pick_valid;
    logic [NUM_CH-1:0]       pick_oh;
    logic [NUM_CH-1:0]       idx_oh;
    logic                    finish_hit;

    ddr_burst_arbiter_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .req   (ch_req_i),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign pick_oh    = NUM_CH'(1) << pick_idx;
    assign idx_oh     = NUM_CH'(1) << idx_q;
    // Only the finish matching the burst direction ends it
    assign finish_hit = (dir_q == DIR_RD) ? rd_ddr_finish_i : wr_ddr_finish_i;

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dir_d     = dir_q;
        zero_d    = zero_q;
        rr_ptr_d  = rr_ptr_q;
        wd_d      = wd_q;
        tcnt_d    = tcnt_q;
        grant_d   = '0;
        done_d    = '0;
        terr_d    = 1'b0;
        rd_req_d  = 1'b0;
        wr_req_d  = 1'b0;
        rd_len_d  = rd_len_q;
        wr_len_d  = wr_len_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid && burst_idle_i && local_init_done_i) begin
                    idx_d   = pick_idx;
                    dir_d   = ch_dir_i[pick_idx];
                    grant_d = pick_oh;
                    wd_d    = '0;
                    if (len_arr[pick_idx] != '0) begin
                        zero_d  = 1'b0;
                        state_d = ST_ISSUE;
                        if (ch_dir_i[pick_idx] == DIR_RD) begin
                            rd_req_d  = 1'b1;
                            rd_len_d  = len_arr[pick_idx];
                            rd_addr_d = addr_arr[pick_idx];
                        end else begin
                            wr_req_d  = 1'b1;
                            wr_len_d  = len_arr[pick_idx];
                            wr_addr_d = addr_arr[pick_idx];
                        end
                    end else begin
                        // Zero-length: no DDR request, done follows in the next cycle
                        zero_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (finish_hit) begin
                    done_d  = idx_oh;
                    state_d = ST_DONE;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    done_d  = idx_oh;
                    terr_d  = 1'b1;
                    state_d = ST_DONE;
                    if (tcnt_q != '1) begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_DONE: begin
                rr_ptr_d = CH_W'(wrap_inc(32'(idx_q), NUM_CH));
                if (zero_q) begin
                    done_d = idx_oh;
                end
                zero_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            dir_q     <= 1'b0;
            zero_q    <= 1'b0;
            rr_ptr_q  <= '0;
            wd_q      <= '0;
            tcnt_q    <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            terr_q    <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            rd_len_q  <= '0;
            wr_len_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dir_q     <= dir_d;
            zero_q    <= zero_d;
            rr_ptr_q  <= rr_ptr_d;
            wd_q      <= wd_d;
            tcnt_q    <= tcnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
            rd_req_q  <= rd_req_d;
            wr_req_q  <= wr_req_d;
            rd_len_q  <= rd_len_d;
            wr_len_q  <= wr_len_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // Beat steering to the granted channel while a burst is in flight
    always_comb begin
        ch_wr_data_req_o = '0;
        ch_rd_valid_o    = '0;
        rd_data_o        = '0;
        wr_ddr_data_o    = '0;
        if (state_q == ST_BUSY) begin
            ch_wr_data_req_o[idx_q] = wr_ddr_data_req_i;
            ch_rd_valid_o[idx_q]    = rd_ddr_data_valid_i;
            rd_data_o               = rd_ddr_data_i;
            wr_ddr_data_o           = data_arr[idx_q];
        end
    end

    assign ch_grant_o    = grant_q;
    assign ch_done_o     = done_q;
    assign timeout_err_o = terr_q;
    assign timeout_cnt_o = tcnt_q;
    assign rd_ddr_req_o  = rd_req_q;
    assign rd_ddr_len_o  = rd_len_q;
    assign rd_ddr_addr_o = rd_addr_q;
    assign wr_ddr_req_o  = wr_req_q;
    assign wr_ddr_len_o  = wr_len_q;
    assign wr_ddr_addr_o = wr_addr_q;

endmodule
